// File: rtl/vga_pkg.sv
// Shared constants and types for the square-drawing pixel generator
// that feeds vga_adapter.
package vga_pkg;
    localparam int SQ_LOG2  = 2;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int CW       = 3;
    localparam int XW       = 8;
    localparam int YW       = 7;

    typedef enum logic [1:0] {IDLE, DRAW, CLEAR} state_t;
endpackage

// File: rtl/vga_draw_square_rise_detect.sv
// Rising-edge detector: one history flop, rise = current & ~previous.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic req,
    output logic rise
);
    logic prev;

    always_ff @(posedge clock) begin
        if (reset) prev <= 1'b0;
        else       prev <= req;
    end

    assign rise = req & ~prev;
endmodule

// File: rtl/vga_draw_square.sv
// Emits a clipped 4x4 square at a stored (X,Y) or a full-screen black
// clear, one registered pixel write per clock toward vga_adapter.
module vga_draw_square
    import vga_pkg::state_t, vga_pkg::IDLE, vga_pkg::DRAW, vga_pkg::CLEAR,
           vga_pkg::XW, vga_pkg::YW, vga_pkg::CW;
#(
    parameter int SQ_LOG2  = vga_pkg::SQ_LOG2,
    parameter int SCREEN_W = vga_pkg::SCREEN_W,
    parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [YW-1:0] pos_in,
    input  logic [CW-1:0] colour_in,
    input  logic          store_pos,
    input  logic          clear_scr,
    input  logic          plot,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          writeEn,
    output logic          busy
);
    localparam int CNT_W    = 2 * SQ_LOG2;
    localparam int LAST_PIX = (1 << CNT_W) - 1;

    logic [2:0] req, rise;
    logic       store_rise, clear_rise, plot_rise;

    assign req = {plot, clear_scr, store_pos};

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_rise
            rise_detect u_rd (
                .clock (clock),
                .reset (reset),
                .req   (req[i]),
                .rise  (rise[i])
            );
        end
    endgenerate

    assign store_rise = rise[0];
    assign clear_rise = rise[1];
    assign plot_rise  = rise[2];

    state_t              state_q, state_d;
    logic [YW-1:0]       pos_x, pos_y, bx, by;
    logic                sel_y;
    logic [CW-1:0]       col;
    logic [CNT_W-1:0]    cnt;
    logic [XW-1:0]       cx;
    logic [YW-1:0]       cy;
    logic [SQ_LOG2-1:0]  dx, dy;
    logic [XW-1:0]       x_sum, y_sum;
    logic                draw_last, clr_last;

    assign dx        = cnt[SQ_LOG2-1:0];
    assign dy        = cnt[CNT_W-1:SQ_LOG2];
    // y is summed one bit wider so rows past the bottom edge can be clipped
    assign x_sum     = XW'(bx) + XW'(dx);
    assign y_sum     = XW'(by) + XW'(dy);
    assign draw_last = (cnt == CNT_W'(LAST_PIX));
    assign clr_last  = (cx == XW'(SCREEN_W - 1)) && (cy == YW'(SCREEN_H - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_rise)     state_d = CLEAR;
                     else if (plot_rise) state_d = DRAW;
            DRAW:    if (draw_last)      state_d = IDLE;
            CLEAR:   if (clr_last)       state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pos_x   <= '0;
            pos_y   <= '0;
            sel_y   <= 1'b0;
            bx      <= '0;
            by      <= '0;
            col     <= '0;
            cnt     <= '0;
            cx      <= '0;
            cy      <= '0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            writeEn <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;

            // Position stores are honoured in every state; an active draw
            // works from its own latched copy.
            if (store_rise) begin
                if (sel_y) pos_y <= pos_in;
                else       pos_x <= pos_in;
                sel_y <= ~sel_y;
            end

            case (state_q)
                DRAW: begin
                    x       <= x_sum;
                    y       <= y_sum[YW-1:0];
                    colour  <= col;
                    writeEn <= (y_sum < XW'(SCREEN_H));
                    busy    <= 1'b1;
                    cnt     <= cnt + 1'b1;
                end
                CLEAR: begin
                    x       <= cx;
                    y       <= cy;
                    colour  <= '0;
                    writeEn <= 1'b1;
                    busy    <= 1'b1;
                    if (cx == XW'(SCREEN_W - 1)) begin
                        cx <= '0;
                        cy <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                default: begin
                    writeEn <= 1'b0;
                    busy    <= 1'b0;
                    if (state_d == DRAW) begin
                        bx  <= pos_x;
                        by  <= pos_y;
                        col <= colour_in;
                        cnt <= '0;
                    end
                    if (state_d == CLEAR) begin
                        cx <= '0;
                        cy <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_draw_square.sv
// Self-checking bench: logs every written pixel and compares it with a
// list built directly from the square / clear-screen rules.
module tb_vga_draw_square;
    typedef logic [17:0] pix_t;   // {x[7:0], y[6:0], colour[2:0]}

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] pos_in = '0;
    logic [2:0] colour_in = '0;
    logic       store_pos = 1'b0, clear_scr = 1'b0, plot = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn, busy;

    int   checks = 0;
    int   errors = 0;
    pix_t pix_q[$];
    pix_t exp_q[$];
    int   busy_cnt = 0;

    vga_draw_square dut (
        .clock     (clock),
        .reset     (reset),
        .pos_in    (pos_in),
        .colour_in (colour_in),
        .store_pos (store_pos),
        .clear_scr (clear_scr),
        .plot      (plot),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .writeEn   (writeEn),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        if (writeEn) pix_q.push_back({x, y, colour});
        if (busy) busy_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_log();
        pix_q.delete();
        busy_cnt = 0;
    endtask

    task automatic press_store(input logic [6:0] v);
        pos_in = v; store_pos = 1'b1; step();
        store_pos = 1'b0; step();
    endtask

    task automatic press_plot(input logic [2:0] c);
        colour_in = c; plot = 1'b1; step();
        plot = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; step();
        reset = 1'b0; step();
    endtask

    task automatic build_square(input int sx, input int sy, input logic [2:0] c);
        exp_q.delete();
        for (int dy = 0; dy < 4; dy++)
            for (int dx = 0; dx < 4; dx++)
                if (sy + dy < 120) exp_q.push_back({8'(sx + dx), 7'(sy + dy), c});
    endtask

    task automatic build_clear();
        exp_q.delete();
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                exp_q.push_back({8'(xx), 7'(yy), 3'd0});
    endtask

    function automatic int first_diff();
        int n = (pix_q.size() < exp_q.size()) ? pix_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (pix_q[i] !== exp_q[i]) return i;
        if (pix_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic check_square(input string name);
        int d;
        checks++;
        if (pix_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", name, pix_q.size(), exp_q.size());
        end
        checks++;
        d = first_diff();
        if (d >= 0 && d < pix_q.size() && d < exp_q.size()) begin
            errors++;
            $display("FAIL %s pixel %0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                     name, d, pix_q[d][17:10], pix_q[d][9:3], pix_q[d][2:0],
                     exp_q[d][17:10], exp_q[d][9:3], exp_q[d][2:0]);
        end
        checks++;
        if (busy_cnt != 16) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d want 16", name, busy_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run(2);
        checks++; if (x !== 8'd0)     begin errors++; $display("FAIL reset_x: got %0d want 0", x); end
        checks++; if (y !== 7'd0)     begin errors++; $display("FAIL reset_y: got %0d want 0", y); end
        checks++; if (colour !== 3'd0) begin errors++; $display("FAIL reset_colour: got %0d want 0", colour); end
        checks++; if (writeEn !== 1'b0) begin errors++; $display("FAIL reset_writeEn: got %b want 0", writeEn); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0; step();
    endtask

    task automatic test_square_basic();
        press_store(7'd10);
        press_store(7'd20);
        clr_log();
        press_plot(3'd5);
        checks++;
        if (pix_q.size() != 0 || busy_cnt != 0) begin
            errors++;
            $display("FAIL latency_early: got %0d writes %0d busy want 0 0", pix_q.size(), busy_cnt);
        end
        step();
        checks++;
        if (pix_q.size() != 1 || busy_cnt != 1) begin
            errors++;
            $display("FAIL latency_first: got %0d writes %0d busy want 1 1", pix_q.size(), busy_cnt);
        end
        run(20);
        build_square(10, 20, 3'd5);
        check_square("square_basic");
    endtask

    task automatic test_random_squares();
        for (int it = 0; it < 6; it++) begin
            int sx = $urandom_range(0, 127);
            int sy = $urandom_range(0, 119);
            logic [2:0] c = 3'($urandom_range(0, 7));
            press_store(7'(sx));
            press_store(7'(sy));
            clr_log();
            press_plot(c);
            run(20);
            build_square(sx, sy, c);
            check_square("square_random");
        end
    endtask

    task automatic test_hold_store();
        do_reset();
        pos_in = 7'd7; store_pos = 1'b1; run(100);
        store_pos = 1'b0; step();
        press_store(7'd33);
        clr_log();
        press_plot(3'd3);
        run(20);
        build_square(7, 33, 3'd3);
        check_square("hold_store");
    endtask

    task automatic test_store_during_draw();
        press_store(7'd40);
        press_store(7'd50);
        clr_log();
        press_plot(3'd1);
        run(3);
        press_store(7'd90);
        run(16);
        build_square(40, 50, 3'd1);
        check_square("store_mid_draw_active");
        press_store(7'd60);
        clr_log();
        press_plot(3'd6);
        run(20);
        build_square(90, 60, 3'd6);
        check_square("store_mid_draw_next");
    endtask

    task automatic test_clip();
        press_store(7'd127);
        press_store(7'd118);
        clr_log();
        press_plot(3'd6);
        run(20);
        build_square(127, 118, 3'd6);
        check_square("clip_bottom");
    endtask

    task automatic test_clear(input string name, input bit both);
        int d;
        clr_log();
        colour_in = 3'd7;
        clear_scr = 1'b1;
        plot = both;
        step();
        clear_scr = 1'b0;
        plot = 1'b0;
        run(50);
        press_plot(3'd2);
        run(19200 + 20);
        build_clear();
        checks++;
        if (pix_q.size() != 19200) begin
            errors++;
            $display("FAIL %s count: got %0d want 19200", name, pix_q.size());
        end
        checks++;
        d = first_diff();
        if (d >= 0 && d < pix_q.size() && d < exp_q.size()) begin
            errors++;
            $display("FAIL %s pixel %0d: got %h want %h", name, d, pix_q[d], exp_q[d]);
        end
        checks++;
        if (pix_q.size() == 0 || pix_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL %s first pixel: got %0d writes want (0,0)", name, pix_q.size());
        end
        checks++;
        if (pix_q.size() < 19200 || pix_q[19199] !== {8'd159, 7'd119, 3'd0}) begin
            errors++;
            $display("FAIL %s last pixel: got %0d writes want (159,119) at 19199", name, pix_q.size());
        end
        checks++;
        if (busy_cnt != 19200) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d want 19200", name, busy_cnt);
        end
    endtask

    task automatic test_reset_mid_draw();
        int n;
        press_store(7'd60);
        press_store(7'd50);
        press_store(7'd61);
        clr_log();
        press_plot(3'd4);
        n = 0;
        while (pix_q.size() < 5 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (pix_q.size() != 5) begin
            errors++;
            $display("FAIL reset_mid_draw reach: got %0d writes want 5", pix_q.size());
        end
        reset = 1'b1; step();
        checks++;
        if (writeEn !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_draw outputs: got we=%b busy=%b want 0 0", writeEn, busy);
        end
        reset = 1'b0;
        run(10);
        checks++;
        if (pix_q.size() != 5) begin
            errors++;
            $display("FAIL reset_mid_draw abort: got %0d writes want 5", pix_q.size());
        end
        clr_log();
        press_plot(3'd1);
        run(20);
        build_square(0, 0, 3'd1);
        check_square("reset_clears_xy");
        press_store(7'd70);
        press_store(7'd80);
        clr_log();
        press_plot(3'd2);
        run(20);
        build_square(70, 80, 3'd2);
        check_square("reset_toggle_x");
    endtask

    initial begin
        test_reset();
        test_square_basic();
        test_random_squares();
        test_hold_store();
        test_store_during_draw();
        test_clip();
        test_clear("clear_ignores_plot", 1'b0);
        test_clear("clear_priority", 1'b1);
        test_reset_mid_draw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_draw_square.md
Name: vga_draw_square

Overview:
- Pixel-generation stage directly upstream of vga_adapter.
- Captures X then Y position from switch input and emits the 16 pixel writes of a 4x4 square at (X,Y) with the selected colour.
- Also emits a full-screen black clear of 160x120.
- Drives the adapter's x, y, colour and plot (writeEn) inputs, one pixel per clock.

Parameters:
- SQ_LOG2, 2, log2 of square side; side = 4.
- SCREEN_W, 160, frame-buffer width in pixels.
- SCREEN_H, 120, frame-buffer height in pixels.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- pos_in  in  7  position value to store, X or Y.
- colour_in  in  3  RGB colour for plot.
- store_pos  in  1  level request: store pos_in; acts on rising edge only.
- clear_scr  in  1  level request: clear screen; acts on rising edge only.
- plot  in  1  level request: draw square; acts on rising edge only.
- x  out  8  pixel column to adapter.
- y  out  7  pixel row to adapter.
- colour  out  3  pixel colour to adapter.
- writeEn  out  1  pixel write strobe to adapter.
- busy  out  1  high while DRAW or CLEAR is active.

Behaviour:
- Reset, synchronous: on a clock edge with reset=1, outputs go to x=0, y=0, colour=0, writeEn=0, busy=0.
  - State goes to IDLE.
  - X and Y registers are cleared to 0.
  - The load-select toggle points to X.
  - Edge-detector history is cleared to 0.
  - Reset mid-DRAW or mid-CLEAR aborts: writeEn=0 from the next cycle onward.
- Edge detection: each request is registered once; rise = current & ~previous. A level held for any duration acts exactly once.
- Store: a store_pos rise in any state loads pos_in into X if the toggle=X, otherwise into Y. The toggle then flips.
  - Stores during DRAW take effect immediately for later plots only. The active draw uses X/Y/colour latched at start.
- States: IDLE, DRAW, CLEAR.
  - IDLE -> CLEAR on a clear_scr rise.
  - IDLE -> DRAW on a plot rise, when there is no clear_scr rise in the same cycle. Clear has priority over plot.
  - DRAW -> IDLE after the 16th pixel.
  - CLEAR -> IDLE after the 19200th pixel.
  - plot and clear_scr rises arriving in DRAW or CLEAR are discarded, not queued.
- DRAW:
  - On entry, latch bx=X, by=Y, col=colour_in.
  - 4-bit counter c, low 2 bits = dx, high 2 bits = dy. Row-major scan, dx fastest.
  - Registered outputs: x = {0,bx}+dx (8-bit), y = by+dy computed 8-bit.
  - writeEn=1 only if the 8-bit y sum < SCREEN_H. Otherwise writeEn=0 and y output = low 7 bits. The cycle is still consumed.
  - x max = 127+3 = 130 < 160, so x is never clipped.
- CLEAR:
  - Counters cx 0..159 and cy 0..119, cx fastest.
  - colour=0, writeEn=1 every cycle; 19200 cycles.
  - Last pixel is (159,119).
- Latency: a request rise sampled at edge k gives the first writeEn=1 output at edge k+1 (registered). Pixels are then on consecutive cycles with no gaps.
  - busy=1 on exactly the cycles where state is DRAW or CLEAR.
  - busy falls on the cycle after the last pixel, together with writeEn.
- A new request is accepted on the first IDLE cycle after completion.

Decomposition:
- Shared package vga_pkg holds:
  - SCREEN_W, SCREEN_H, SQ_LOG2 constants.
  - State enum {IDLE, DRAW, CLEAR}.
  - Colour width 3, x width 8, y width 7.
- Sub-module rise_detect: 1-bit register plus AND-NOT, sync reset. Instanced three times, once each for store_pos, clear_scr and plot.

Test Plan:
- Reset, store 10, store 20, plot with colour_in=5 -> exactly 16 writeEn cycles at (10..13,20..23), row-major, colour 5; busy high for 16 cycles.
- Hold store_pos high 100 cycles with pos_in=7, then release -> only X=7 loaded; next press loads Y.
- clear_scr rise -> 19200 consecutive writeEn cycles with colour 0, first (0,0), last (159,119).
  - A plot rise mid-clear is ignored: total writes are 19200 and there is no draw afterwards.
- X=127, Y=118, plot -> 8 writes (rows 118 and 119, x 127..130); rows 120 and 121 suppressed; still 16 busy cycles.
- clear_scr and plot rise in the same cycle -> CLEAR runs, no DRAW.
- Reset asserted on the 5th DRAW pixel -> writeEn=0 from the next cycle; toggle back to X (next store loads X).
